tiny_cpu_core_p: RTL and testbench

- Parametrised successor of the team's 8-bit tiny CPU.
- Multi-cycle, non-pipelined core with a 16-bit instruction word and generic data width.
- Instruction memory is loaded externally before `run`; supports conditional branches, jumps, sign-extended immediates and a valid/ready output port that stalls the core.
- Sits behind the TT pin wrapper, which maps ui/uio pins onto its ports.

---
 rtl/tiny_cpu_pkg.sv | 61 ++++++
 rtl/tiny_cpu_core_p_if.sv | 33 +++
 rtl/tiny_cpu_alu_p.sv | 37 +++
 rtl/tiny_cpu_core_p.sv | 209 ++++++++++++++++++++
 tb/tb_tiny_cpu_core_p.sv | 394 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tiny_cpu_pkg.sv
// Shared definitions for the parametrised tiny CPU core.
// Holds the state encodings, opcode and ALU funct constants, instruction
// field positions and a decode helper that splits a 16-bit word into fields.
package tiny_cpu_pkg;

  // State encodings are visible on the debug pins, so their values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_EXEC     = 3'd2,
    ST_WB       = 3'd3,
    ST_OUT_WAIT = 3'd4,
    ST_HALT     = 3'd5
  } state_e;

  // Opcodes 0x0-0x7 are register ALU ops; op[2:0] doubles as the ALU funct.
  localparam logic [3:0] OP_ADDI  = 4'h8;
  localparam logic [3:0] OP_LOAD  = 4'h9;
  localparam logic [3:0] OP_STORE = 4'hA;
  localparam logic [3:0] OP_BEQ   = 4'hB;
  localparam logic [3:0] OP_BNE   = 4'hC;
  localparam logic [3:0] OP_JMP   = 4'hD;
  localparam logic [3:0] OP_NOP   = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [2:0] FN_ADD = 3'd0;
  localparam logic [2:0] FN_SUB = 3'd1;
  localparam logic [2:0] FN_AND = 3'd2;
  localparam logic [2:0] FN_OR  = 3'd3;
  localparam logic [2:0] FN_XOR = 3'd4;
  localparam logic [2:0] FN_SLL = 3'd5;
  localparam logic [2:0] FN_SRL = 3'd6;
  localparam logic [2:0] FN_MUL = 3'd7;

  // Instruction field bit positions.
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [5:0] imm;   // rs2 is imm[2:0]
  } instr_t;

  function automatic instr_t decode(input logic [15:0] word);
    instr_t f;
    f.op  = word[OP_MSB:OP_LSB];
    f.rd  = word[RD_MSB:RD_LSB];
    f.rs1 = word[RS1_MSB:RS1_LSB];
    f.imm = word[IMM_MSB:IMM_LSB];
    return f;
  endfunction

endpackage

// File: rtl/tiny_cpu_core_p_if.sv
// Bus bundle between the tiny CPU core and its host (pin wrapper or bench).
// Carries the program-load port, run strobe, load sources, the valid/ready
// store port and the status/debug outputs.
// master: host side (drives program, run, inputs, out_ready).
// slave : core side (drives out_data/out_valid and status).
interface tiny_cpu_core_p_if #(
  parameter int DATA_WIDTH = 8,
  parameter int IMEM_AW    = 4
);
  logic                  prog_we;
  logic [IMEM_AW-1:0]    prog_addr;
  logic [15:0]           prog_data;
  logic                  run;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic                  halted;
  logic [IMEM_AW-1:0]    pc_out;
  logic [2:0]            state_out;

  modport master (
    output prog_we, prog_addr, prog_data, run, in_a, in_b, out_ready,
    input  out_data, out_valid, busy, halted, pc_out, state_out
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, run, in_a, in_b, out_ready,
    output out_data, out_valid, busy, halted, pc_out, state_out
  );
endinterface

// File: rtl/tiny_cpu_alu_p.sv
// Combinational ALU for the tiny CPU core.
// Ports: a, b (DATA_WIDTH operands), funct (3-bit op select), result.
// All arithmetic wraps modulo 2**DATA_WIDTH; shifts use b mod DATA_WIDTH;
// MUL keeps the low DATA_WIDTH bits of the product.
module tiny_cpu_alu_p
  import tiny_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [2:0]            funct,
  output logic [DATA_WIDTH-1:0] result
);
  localparam int SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0] shamt_s;

  // DATA_WIDTH is a power of two, so the low bits are exactly b mod DATA_WIDTH.
  assign shamt_s = b[SHW-1:0];

  // Operation select.
  always_comb begin
    result = '0;
    case (funct)
      FN_ADD:  result = a + b;
      FN_SUB:  result = a - b;
      FN_AND:  result = a & b;
      FN_OR:   result = a | b;
      FN_XOR:  result = a ^ b;
      FN_SLL:  result = a << shamt_s;
      FN_SRL:  result = a >> shamt_s;
      FN_MUL:  result = a * b;
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/tiny_cpu_core_p.sv
// Multi-cycle, non-pipelined tiny CPU core with 16-bit instructions.
// Ports: clk, rst (async active-high), bus (slave side of tiny_cpu_core_p_if):
//   program load (prog_we/prog_addr/prog_data), run strobe, load sources
//   in_a/in_b, valid/ready store port, busy/halted/pc_out/state_out status.
// Register file x0..x7 (x0 reads zero) and instruction memory are inline.
module tiny_cpu_core_p
  import tiny_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMEM_AW    = 4
) (
  input  logic            clk,
  input  logic            rst,
  tiny_cpu_core_p_if.slave bus
);
  localparam int DEPTH = 2 ** IMEM_AW;
  localparam logic [IMEM_AW-1:0] PC_ONE = IMEM_AW'(1);

  state_e                state_q, state_d;
  logic [IMEM_AW-1:0]    pc_q, pc_d;
  logic [15:0]           ir_q, ir_d;
  logic [DATA_WIDTH-1:0] regs_q [8];
  logic [DATA_WIDTH-1:0] regs_d [8];
  logic [15:0]           imem_q [DEPTH];
  logic [15:0]           imem_d [DEPTH];
  logic [DATA_WIDTH-1:0] alu_res_q, alu_res_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic                  halted_q, halted_d;

  instr_t                ins_s;
  logic [DATA_WIDTH-1:0] rs1_val_s, rs2_val_s, rd_val_s, imm_sext_s;
  logic [DATA_WIDTH-1:0] alu_b_s, alu_y_s;
  logic [2:0]            alu_fn_s;
  logic [IMEM_AW-1:0]    br_off_s, jmp_tgt_s;

  // Immediate sign-extended to pc width (pc arithmetic wraps modulo 2**IMEM_AW).
  function automatic logic [IMEM_AW-1:0] pc_sext(input logic [5:0] imm);
    logic [IMEM_AW-1:0] r;
    for (int i = 0; i < IMEM_AW; i++) begin
      r[i] = (i < 6) ? imm[i] : imm[5];
    end
    return r;
  endfunction

  // Immediate zero-extended or truncated to pc width for JMP.
  function automatic logic [IMEM_AW-1:0] pc_zext(input logic [5:0] imm);
    logic [IMEM_AW-1:0] r;
    for (int i = 0; i < IMEM_AW; i++) begin
      r[i] = (i < 6) ? imm[i] : 1'b0;
    end
    return r;
  endfunction

  assign ins_s      = decode(ir_q);
  assign rs1_val_s  = regs_q[ins_s.rs1];
  assign rs2_val_s  = regs_q[ins_s.imm[2:0]];
  assign rd_val_s   = regs_q[ins_s.rd];
  assign imm_sext_s = {{(DATA_WIDTH-6){ins_s.imm[5]}}, ins_s.imm};
  assign br_off_s   = pc_sext(ins_s.imm);
  assign jmp_tgt_s  = pc_zext(ins_s.imm);

  // ADDI shares the ALU adder with the immediate in place of rs2.
  assign alu_fn_s = (ins_s.op == OP_ADDI) ? FN_ADD : ins_s.op[2:0];
  assign alu_b_s  = (ins_s.op == OP_ADDI) ? imm_sext_s : rs2_val_s;

  tiny_cpu_alu_p #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a      (rs1_val_s),
    .b      (alu_b_s),
    .funct  (alu_fn_s),
    .result (alu_y_s)
  );

  // Next-state logic for the FSM, datapath registers, register file and imem.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    regs_d      = regs_q;
    imem_d      = imem_q;
    alu_res_d   = alu_res_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        // The write lands on the same edge that starts the core, so the
        // first fetch already sees it.
        if (bus.prog_we) begin
          imem_d[bus.prog_addr] = bus.prog_data;
        end else begin
          imem_d = imem_q;
        end
        if (bus.run) begin
          pc_d    = '0;
          state_d = ST_FETCH;
        end else begin
          state_d = state_q;
        end
      end
      ST_FETCH: begin
        ir_d    = imem_q[pc_q];
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (ins_s.op)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, OP_ADDI: begin
            alu_res_d = alu_y_s;
            state_d   = ST_WB;
          end
          OP_LOAD: begin
            regs_d[ins_s.rd] = ins_s.imm[0] ? bus.in_b : bus.in_a;
            pc_d             = pc_q + PC_ONE;
            state_d          = ST_FETCH;
          end
          OP_STORE: begin
            out_data_d  = rs1_val_s;
            out_valid_d = 1'b1;
            state_d     = ST_OUT_WAIT;
          end
          OP_BEQ: begin
            pc_d    = (rd_val_s == rs1_val_s) ? pc_q + br_off_s : pc_q + PC_ONE;
            state_d = ST_FETCH;
          end
          OP_BNE: begin
            pc_d    = (rd_val_s != rs1_val_s) ? pc_q + br_off_s : pc_q + PC_ONE;
            state_d = ST_FETCH;
          end
          OP_JMP: begin
            pc_d    = jmp_tgt_s;
            state_d = ST_FETCH;
          end
          OP_NOP: begin
            pc_d    = pc_q + PC_ONE;
            state_d = ST_FETCH;
          end
          OP_HALT: begin
            state_d = ST_HALT;
          end
          default: begin
            pc_d    = pc_q + PC_ONE;
            state_d = ST_FETCH;
          end
        endcase
      end
      ST_WB: begin
        regs_d[ins_s.rd] = alu_res_q;
        pc_d             = pc_q + PC_ONE;
        state_d          = ST_FETCH;
      end
      ST_OUT_WAIT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          pc_d        = pc_q + PC_ONE;
          state_d     = ST_FETCH;
        end else begin
          state_d = ST_OUT_WAIT;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // x0 is hardwired to zero; any write to it is discarded here.
    regs_d[0] = '0;

    busy_d   = (state_d == ST_FETCH) || (state_d == ST_EXEC) ||
               (state_d == ST_WB)    || (state_d == ST_OUT_WAIT);
    halted_d = (state_d == ST_HALT);
  end

  // All core state; reset clears everything, including imem, and drops
  // out_valid without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      regs_q      <= '{default: '0};
      imem_q      <= '{default: '0};
      alu_res_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      regs_q      <= regs_d;
      imem_q      <= imem_d;
      alu_res_q   <= alu_res_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.halted    = halted_q;
  assign bus.pc_out    = pc_q;
  assign bus.state_out = state_q;
endmodule

// File: tb/tb_tiny_cpu_core_p.sv
module tb_tiny_cpu_core_p;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [15:0] prog [16];
  logic [15:0] got [$];
  int          got_cyc [$];
  bit          saw15;
  bit          wrapped;

  tiny_cpu_core_p_if #(.DATA_WIDTH(8),  .IMEM_AW(4)) b8 ();
  tiny_cpu_core_p_if #(.DATA_WIDTH(16), .IMEM_AW(4)) b16 ();

  tiny_cpu_core_p #(.DATA_WIDTH(8), .IMEM_AW(4)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8)
  );

  tiny_cpu_core_p #(.DATA_WIDTH(16), .IMEM_AW(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (b16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [5:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  function automatic logic [15:0] o_data(input bit w);
    return w ? b16.out_data : {8'h00, b8.out_data};
  endfunction
  function automatic logic o_valid(input bit w);
    return w ? b16.out_valid : b8.out_valid;
  endfunction
  function automatic logic o_ready(input bit w);
    return w ? b16.out_ready : b8.out_ready;
  endfunction
  function automatic logic o_halted(input bit w);
    return w ? b16.halted : b8.halted;
  endfunction
  function automatic logic [3:0] o_pc(input bit w);
    return w ? b16.pc_out : b8.pc_out;
  endfunction

  task automatic set_ready(input bit w, input logic v);
    if (w) b16.out_ready = v;
    else   b8.out_ready  = v;
  endtask

  task automatic drive_prog(input bit w, input logic we, input int a, input logic [15:0] d);
    if (w) begin
      b16.prog_we = we; b16.prog_addr = 4'(a); b16.prog_data = d;
    end else begin
      b8.prog_we = we; b8.prog_addr = 4'(a); b8.prog_data = d;
    end
  endtask

  task automatic load(input bit w, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      @(negedge clk);
      drive_prog(w, 1'b1, i, prog[i]);
    end
    @(negedge clk);
    drive_prog(w, 1'b0, 0, 16'h0000);
  endtask

  // Run pulse, optionally with a program write in the same cycle.
  task automatic start(input bit w, input logic we, input int a, input logic [15:0] d);
    @(negedge clk);
    drive_prog(w, we, a, d);
    if (w) b16.run = 1'b1; else b8.run = 1'b1;
    @(negedge clk);
    drive_prog(w, 1'b0, 0, 16'h0000);
    b16.run = 1'b0;
    b8.run  = 1'b0;
  endtask

  // Records every accepted store until the core halts or the budget runs out.
  task automatic collect(input bit w, input int budget);
    int cyc;
    cyc = 0;
    got.delete();
    got_cyc.delete();
    saw15   = 1'b0;
    wrapped = 1'b0;
    while (!o_halted(w) && cyc < budget) begin
      if (o_valid(w) && o_ready(w)) begin
        got.push_back(o_data(w));
        got_cyc.push_back(cyc);
      end
      if (o_pc(w) == 4'd15) saw15 = 1'b1;
      else if (saw15 && o_pc(w) == 4'd0) wrapped = 1'b1;
      @(negedge clk);
      cyc++;
    end
    total++;
    if (!o_halted(w)) begin
      bad++;
      $display("FAIL halt_timeout: halted=%0b required=1 after %0d cycles", o_halted(w), cyc);
    end
  endtask

  task automatic wait_valid(input bit w, input int budget);
    int cyc;
    cyc = 0;
    while (!o_valid(w) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (!o_valid(w)) begin
      bad++;
      $display("FAIL valid_timeout: out_valid=0 required=1 after %0d cycles", cyc);
    end
  endtask

  function automatic logic [15:0] got_at(input int i);
    return (got.size() > i) ? got[i] : 16'hxxxx;
  endfunction

  task automatic test_reset();
    #12;
    total++;
    if (b8.out_valid !== 1'b0 || b8.busy !== 1'b0 || b8.halted !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: valid=%b busy=%b halted=%b required 0 0 0",
               b8.out_valid, b8.busy, b8.halted);
    end
    total++;
    if (b8.pc_out !== 4'd0 || b8.state_out !== 3'd0 || b8.out_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_state: pc=%0d state=%0d data=%h required 0 0 00",
               b8.pc_out, b8.state_out, b8.out_data);
    end
    total++;
    if (b16.state_out !== 3'd0 || b16.out_data !== 16'h0000) begin
      bad++;
      $display("FAIL reset_w16: state=%0d data=%h required 0 0000", b16.state_out, b16.out_data);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_arith();
    prog[0] = enc(4'h9, 3'd1, 3'd0, 6'd0);
    prog[1] = enc(4'h9, 3'd2, 3'd0, 6'd1);
    prog[2] = enc(4'h0, 3'd3, 3'd1, 6'd2);
    prog[3] = enc(4'hA, 3'd0, 3'd3, 6'd0);
    prog[4] = enc(4'h1, 3'd4, 3'd1, 6'd2);
    prog[5] = enc(4'hA, 3'd0, 3'd4, 6'd0);
    prog[6] = enc(4'hF, 3'd0, 3'd0, 6'd0);
    b8.in_a = 8'h25;
    b8.in_b = 8'h13;
    set_ready(1'b0, 1'b1);
    load(1'b0, 0, 7);
    start(1'b0, 1'b0, 0, 16'h0000);
    collect(1'b0, 200);
    total++;
    if (got.size() !== 2) begin
      bad++;
      $display("FAIL arith_count: stores=%0d required=2", got.size());
    end
    total++;
    if (got_at(0) !== 16'h0038) begin
      bad++;
      $display("FAIL arith_add: got=%h required=0038", got_at(0));
    end
    total++;
    if (got_at(1) !== 16'h0012) begin
      bad++;
      $display("FAIL arith_sub: got=%h required=0012", got_at(1));
    end
    total++;
    if (got_cyc.size() < 2 || (got_cyc[1] - got_cyc[0] - 1) !== 5) begin
      bad++;
      $display("FAIL store_spacing: gap=%0d required=5",
               (got_cyc.size() < 2) ? -1 : got_cyc[1] - got_cyc[0] - 1);
    end
    total++;
    if (b8.pc_out !== 4'd6 || b8.state_out !== 3'd5 || b8.busy !== 1'b0) begin
      bad++;
      $display("FAIL arith_halt: pc=%0d state=%0d busy=%b required 6 5 0",
               b8.pc_out, b8.state_out, b8.busy);
    end
  endtask

  // Also checks that a write issued together with run is seen by the first fetch.
  task automatic test_countdown();
    prog[0] = enc(4'h8, 3'd1, 3'd0, 6'd5);
    prog[1] = enc(4'hA, 3'd0, 3'd1, 6'd0);
    prog[2] = enc(4'h8, 3'd1, 3'd1, 6'h3F);
    prog[3] = enc(4'hC, 3'd1, 3'd0, 6'h3E);
    prog[4] = enc(4'hF, 3'd0, 3'd0, 6'd0);
    load(1'b0, 1, 4);
    start(1'b0, 1'b1, 0, prog[0]);
    collect(1'b0, 300);
    total++;
    if (got.size() !== 5) begin
      bad++;
      $display("FAIL countdown_count: stores=%0d required=5", got.size());
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (got_at(i) !== 16'(5 - i)) begin
        bad++;
        $display("FAIL countdown_val[%0d]: got=%h required=%h", i, got_at(i), 16'(5 - i));
      end
    end
    total++;
    if (b8.pc_out !== 4'd4 || b8.halted !== 1'b1) begin
      bad++;
      $display("FAIL countdown_halt: pc=%0d halted=%b required 4 1", b8.pc_out, b8.halted);
    end
  endtask

  task automatic test_backpressure();
    prog[0] = enc(4'h9, 3'd5, 3'd0, 6'd0);
    prog[1] = enc(4'hA, 3'd0, 3'd5, 6'd0);
    prog[2] = enc(4'hF, 3'd0, 3'd0, 6'd0);
    b8.in_a = 8'hA5;
    set_ready(1'b0, 1'b0);
    load(1'b0, 0, 3);
    start(1'b0, 1'b0, 0, 16'h0000);
    wait_valid(1'b0, 20);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (b8.out_valid !== 1'b1 || b8.out_data !== 8'hA5 || b8.pc_out !== 4'd1 ||
          b8.state_out !== 3'd4) begin
        bad++;
        $display("FAIL stall[%0d]: valid=%b data=%h pc=%0d state=%0d required 1 a5 1 4",
                 i, b8.out_valid, b8.out_data, b8.pc_out, b8.state_out);
      end
      @(negedge clk);
    end
    set_ready(1'b0, 1'b1);
    collect(1'b0, 50);
    total++;
    if (got.size() !== 1 || got_at(0) !== 16'h00A5) begin
      bad++;
      $display("FAIL stall_release: stores=%0d data=%h required 1 00a5", got.size(), got_at(0));
    end
    total++;
    if (b8.pc_out !== 4'd2) begin
      bad++;
      $display("FAIL stall_pc: pc=%0d required=2", b8.pc_out);
    end
  endtask

  task automatic test_w16();
    prog[0]  = enc(4'h9, 3'd1, 3'd0, 6'd0);
    prog[1]  = enc(4'h9, 3'd2, 3'd0, 6'd1);
    prog[2]  = enc(4'h7, 3'd3, 3'd1, 6'd2);
    prog[3]  = enc(4'hA, 3'd0, 3'd3, 6'd0);
    prog[4]  = enc(4'h8, 3'd4, 3'd0, 6'd17);
    prog[5]  = enc(4'h8, 3'd5, 3'd0, 6'd3);
    prog[6]  = enc(4'h5, 3'd6, 3'd5, 6'd4);
    prog[7]  = enc(4'hA, 3'd0, 3'd6, 6'd0);
    prog[8]  = enc(4'h8, 3'd7, 3'd0, 6'h20);
    prog[9]  = enc(4'hA, 3'd0, 3'd7, 6'd0);
    prog[10] = enc(4'hF, 3'd0, 3'd0, 6'd0);
    b16.in_a = 16'h0123;
    b16.in_b = 16'h0100;
    set_ready(1'b1, 1'b1);
    load(1'b1, 0, 11);
    start(1'b1, 1'b0, 0, 16'h0000);
    collect(1'b1, 300);
    total++;
    if (got_at(0) !== 16'h2300) begin
      bad++;
      $display("FAIL w16_mul: got=%h required=2300", got_at(0));
    end
    total++;
    if (got_at(1) !== 16'h0006) begin
      bad++;
      $display("FAIL w16_sll17: got=%h required=0006", got_at(1));
    end
    total++;
    if (got_at(2) !== 16'hFFE0) begin
      bad++;
      $display("FAIL w16_addi_neg: got=%h required=ffe0", got_at(2));
    end
  endtask

  task automatic test_busy_write();
    prog[0] = enc(4'h9, 3'd5, 3'd0, 6'd0);
    prog[1] = enc(4'hA, 3'd0, 3'd5, 6'd0);
    prog[2] = enc(4'hF, 3'd0, 3'd0, 6'd0);
    b8.in_a = 8'h5A;
    set_ready(1'b0, 1'b0);
    load(1'b0, 0, 3);
    start(1'b0, 1'b0, 0, 16'h0000);
    wait_valid(1'b0, 20);
    drive_prog(1'b0, 1'b1, 2, enc(4'hE, 3'd0, 3'd0, 6'd0));
    @(negedge clk);
    drive_prog(1'b0, 1'b0, 0, 16'h0000);
    set_ready(1'b0, 1'b1);
    collect(1'b0, 50);
    total++;
    if (got_at(0) !== 16'h005A || b8.pc_out !== 4'd2) begin
      bad++;
      $display("FAIL busy_write: data=%h pc=%0d required 005a 2", got_at(0), b8.pc_out);
    end
  endtask

  task automatic test_reset_mid_store();
    set_ready(1'b0, 1'b0);
    start(1'b0, 1'b0, 0, 16'h0000);
    wait_valid(1'b0, 20);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (b8.out_valid !== 1'b0 || b8.state_out !== 3'd0 || b8.busy !== 1'b0 ||
        b8.out_data !== 8'h00 || b8.pc_out !== 4'd0) begin
      bad++;
      $display("FAIL reset_mid_store: valid=%b state=%0d busy=%b data=%h pc=%0d required 0 0 0 00 0",
               b8.out_valid, b8.state_out, b8.busy, b8.out_data, b8.pc_out);
    end
    @(negedge clk);
    rst = 1'b0;
    prog[0] = enc(4'hA, 3'd0, 3'd5, 6'd0);
    prog[1] = enc(4'hF, 3'd0, 3'd0, 6'd0);
    set_ready(1'b0, 1'b1);
    load(1'b0, 0, 2);
    start(1'b0, 1'b0, 0, 16'h0000);
    collect(1'b0, 50);
    total++;
    if (got.size() !== 1 || got_at(0) !== 16'h0000) begin
      bad++;
      $display("FAIL reset_regs: stores=%0d x5=%h required 1 0000", got.size(), got_at(0));
    end
  endtask

  task automatic test_wrap();
    prog[0]  = enc(4'h8, 3'd0, 3'd0, 6'd7);
    prog[1]  = enc(4'hA, 3'd0, 3'd0, 6'd0);
    prog[2]  = enc(4'hC, 3'd1, 3'd0, 6'd3);
    prog[3]  = enc(4'h8, 3'd1, 3'd0, 6'd1);
    prog[4]  = enc(4'hD, 3'd0, 3'd0, 6'd15);
    prog[5]  = enc(4'hF, 3'd0, 3'd0, 6'd0);
    prog[15] = enc(4'hE, 3'd0, 3'd0, 6'd0);
    set_ready(1'b0, 1'b1);
    load(1'b0, 0, 6);
    load(1'b0, 15, 1);
    start(1'b0, 1'b0, 0, 16'h0000);
    collect(1'b0, 100);
    total++;
    if (!(saw15 && wrapped)) begin
      bad++;
      $display("FAIL pc_wrap: saw15=%b wrapped=%b required 1 1", saw15, wrapped);
    end
    total++;
    if (got.size() !== 2 || got_at(0) !== 16'h0000 || got_at(1) !== 16'h0000) begin
      bad++;
      $display("FAIL x0_write: stores=%0d d0=%h d1=%h required 2 0000 0000",
               got.size(), got_at(0), got_at(1));
    end
    total++;
    if (b8.pc_out !== 4'd5) begin
      bad++;
      $display("FAIL wrap_halt_pc: pc=%0d required=5", b8.pc_out);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    b8.prog_we = 1'b0;  b8.prog_addr = 4'd0;  b8.prog_data = 16'h0000;
    b8.run = 1'b0;      b8.in_a = 8'h00;      b8.in_b = 8'h00;  b8.out_ready = 1'b0;
    b16.prog_we = 1'b0; b16.prog_addr = 4'd0; b16.prog_data = 16'h0000;
    b16.run = 1'b0;     b16.in_a = 16'h0000;  b16.in_b = 16'h0000; b16.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) prog[i] = 16'h0000;

    test_reset();
    test_arith();
    test_countdown();
    test_backpressure();
    test_w16();
    test_busy_write();
    test_reset_mid_store();
    test_wrap();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
